// File: rtl/viterbi_code_sync_pkg.sv
// rtl/viterbi_code_sync_pkg.sv - shared defaults and FSM state type for the code-symbol synchroniser
package viterbi_code_sync_pkg;

    localparam int WD_CODE_DEF   = 2;
    localparam int SYM_DIV_DEF   = 8;
    localparam int ZERO_RUN_DEF  = 32;
    localparam int FLUSH_LEN_DEF = 48;
    localparam int CNT_W_DEF     = 16;

    // Encoding 2'd3 is unused and falls back to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_FLUSH  = 2'd2
    } sync_state_e;

endpackage

// File: rtl/viterbi_code_sync_if.sv
// rtl/viterbi_code_sync_if.sv - raw symbol input and decoder-facing outputs of the synchroniser
interface viterbi_code_sync_if #(
    parameter int WD_CODE = 2,
    parameter int CNT_W   = 16
);
    logic [WD_CODE-1:0] code_in;
    logic [WD_CODE-1:0] code;
    logic               sym_strobe;
    logic               active;
    logic               burst_end;
    logic [CNT_W-1:0]   sym_count;

    modport master (
        output code_in,
        input  code, sym_strobe, active, burst_end, sym_count
    );

    modport slave (
        input  code_in,
        output code, sym_strobe, active, burst_end, sym_count
    );
endinterface

// File: rtl/viterbi_sym_timing.sv
// rtl/viterbi_sym_timing.sv - CodeIn synchroniser, symbol timing recovery and mid-symbol sampling
module viterbi_sym_timing
    import viterbi_code_sync_pkg::*;
#(
    parameter int WD_CODE = WD_CODE_DEF,
    parameter int SYM_DIV = SYM_DIV_DEF
)(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [WD_CODE-1:0] i_code_in,
    output logic [WD_CODE-1:0] o_code,
    output logic               o_sym_strobe,
    output logic               o_sample,
    output logic [WD_CODE-1:0] o_sample_sym
);

    localparam int              PH_W    = $clog2(SYM_DIV);
    localparam logic [PH_W-1:0] PH_MID  = PH_W'(SYM_DIV / 2);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(SYM_DIV - 1);

    logic [WD_CODE-1:0] r_s1;
    logic [WD_CODE-1:0] r_s2;
    logic [WD_CODE-1:0] r_s3;
    logic [PH_W-1:0]    r_phase;
    logic [WD_CODE-1:0] r_code;
    logic               r_sym_strobe;
    logic               w_trans;
    logic               w_sample;

    assign w_trans  = (r_s2 != r_s3);
    // A transition re-centres the phase and suppresses a sample on the same cycle.
    assign w_sample = (r_phase == PH_MID) && !w_trans;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1         <= '0;
            r_s2         <= '0;
            r_s3         <= '0;
            r_phase      <= '0;
            r_code       <= '0;
            r_sym_strobe <= 1'b0;
        end else begin
            r_s1         <= i_code_in;
            r_s2         <= r_s1;
            r_s3         <= r_s2;
            if (w_trans || r_phase == PH_LAST) r_phase <= '0;
            else                               r_phase <= r_phase + PH_W'(1);
            if (w_sample) r_code <= r_s2;
            r_sym_strobe <= w_sample;
        end
    end

    assign o_code       = r_code;
    assign o_sym_strobe = r_sym_strobe;
    assign o_sample     = w_sample;
    assign o_sample_sym = r_s2;

endmodule

// File: rtl/viterbi_code_sync.sv
// rtl/viterbi_code_sync.sv - burst detection FSM generating the decoder Active window and symbol count
module viterbi_code_sync
    import viterbi_code_sync_pkg::*;
#(
    parameter int WD_CODE   = WD_CODE_DEF,
    parameter int SYM_DIV   = SYM_DIV_DEF,
    parameter int ZERO_RUN  = ZERO_RUN_DEF,
    parameter int FLUSH_LEN = FLUSH_LEN_DEF,
    parameter int CNT_W     = CNT_W_DEF
)(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    viterbi_code_sync_if.slave   bus
);

    localparam int               ZC_W    = $clog2(ZERO_RUN + 1);
    localparam int               FC_W    = $clog2(FLUSH_LEN + 1);
    localparam logic [CNT_W-1:0] SYM_MAX = {CNT_W{1'b1}};

    logic               w_sample;
    logic [WD_CODE-1:0] w_sample_sym;
    logic               w_nonzero;
    sync_state_e        r_state;
    sync_state_e        w_state_nxt;
    logic               w_active_nxt;
    logic               w_burst_end_nxt;
    logic               r_active;
    logic               r_burst_end;
    logic [ZC_W-1:0]    r_zero_cnt;
    logic [FC_W-1:0]    r_flush_cnt;
    logic [CNT_W-1:0]   r_sym_count;

    viterbi_sym_timing #(
        .WD_CODE (WD_CODE),
        .SYM_DIV (SYM_DIV)
    ) u_sym_timing (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_code_in    (bus.code_in),
        .o_code       (bus.code),
        .o_sym_strobe (bus.sym_strobe),
        .o_sample     (w_sample),
        .o_sample_sym (w_sample_sym)
    );

    assign w_nonzero = |w_sample_sym;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_active    <= 1'b0;
            r_burst_end <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_active    <= w_active_nxt;
            r_burst_end <= w_burst_end_nxt;
        end
    end

    // Transitions fire on the sample where a counter reaches its limit.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_sample && w_nonzero) w_state_nxt = ST_LOCKED;
            end
            ST_LOCKED: begin
                if (w_sample && !w_nonzero && r_zero_cnt == ZC_W'(ZERO_RUN - 1))
                    w_state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (w_sample) begin
                    if (w_nonzero)
                        w_state_nxt = ST_LOCKED;
                    else if (r_flush_cnt == FC_W'(FLUSH_LEN - 1))
                        w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_active_nxt    = (w_state_nxt != ST_IDLE);
        w_burst_end_nxt = (r_state == ST_FLUSH) && (w_state_nxt == ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_zero_cnt  <= '0;
            r_flush_cnt <= '0;
            r_sym_count <= '0;
        end else if (w_sample) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_nonzero) begin
                        r_zero_cnt  <= '0;
                        r_sym_count <= CNT_W'(1);
                    end
                end
                ST_LOCKED, ST_FLUSH: begin
                    if (r_sym_count != SYM_MAX) r_sym_count <= r_sym_count + CNT_W'(1);
                    if (w_nonzero)                 r_zero_cnt <= '0;
                    else if (r_state == ST_LOCKED) r_zero_cnt <= r_zero_cnt + ZC_W'(1);
                    // Held at zero throughout LOCKED so FLUSH always starts from a clean count.
                    if (r_state == ST_LOCKED)      r_flush_cnt <= '0;
                    else if (!w_nonzero)           r_flush_cnt <= r_flush_cnt + FC_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.active    = r_active;
    assign bus.burst_end = r_burst_end;
    assign bus.sym_count = r_sym_count;

endmodule

// File: tb/tb_viterbi_code_sync.sv
// tb/tb_viterbi_code_sync.sv - self-checking bench for viterbi_code_sync with a symbol-level reference model
module tb_viterbi_code_sync;

    localparam int SYM  = 8;
    localparam int ZR   = 32;
    localparam int FL   = 48;
    localparam int CW   = 7;
    localparam int MAXC = (1 << CW) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    viterbi_code_sync_if #(.WD_CODE(2), .CNT_W(CW)) intf ();

    viterbi_code_sync #(.CNT_W(CW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (intf)
    );

    typedef struct {
        logic [31:0] code;
        logic [31:0] act;
        logic [31:0] be;
        logic [31:0] cnt;
        int          cyc;
    } obs_t;

    int         n_chk    = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    int         be_total = 0;
    int         glitch   = 0;
    logic       prev_act = 1'b0;
    obs_t       obs_q[$];
    obs_t       mon_o;
    logic [1:0] stim_q[$];

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (intf.sym_strobe) begin
                mon_o.code = 32'(intf.code);
                mon_o.act  = 32'(intf.active);
                mon_o.be   = 32'(intf.burst_end);
                mon_o.cnt  = 32'(intf.sym_count);
                mon_o.cyc  = cyc;
                obs_q.push_back(mon_o);
            end else if (intf.active !== prev_act || intf.burst_end !== 1'b0) begin
                glitch++;
            end
            if (intf.burst_end === 1'b1) be_total++;
        end
        prev_act = intf.active;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic drive_stim(input bit jit);
        int         t = 0;
        int         tgt;
        int         j;
        logic [1:0] cur;
        cur = intf.code_in;
        for (int k = 0; k < stim_q.size(); k++) begin
            j = 0;
            if (jit && k > 0 && stim_q[k] != cur) j = int'($urandom_range(2)) - 1;
            tgt = k * SYM + j;
            while (t < tgt) begin @(negedge clk); t++; end
            intf.code_in = stim_q[k];
            cur          = stim_q[k];
        end
        while (t < stim_q.size() * SYM + 3 * SYM) begin @(negedge clk); t++; end
    endtask

    // Burst ends once a zero run reaches ZR+FL symbols; Active and SymCount follow from that.
    task automatic check_stim(input string tag, input bit spacing);
        bit act  = 0;
        int zrun = 0;
        int cnt  = 0;
        bit be;
        int n;
        while (obs_q.size() > 0 && obs_q[0].code == 0 && obs_q[0].act == 0) void'(obs_q.pop_front());
        check({tag, " strobes"}, 32'(obs_q.size() >= stim_q.size()), 32'd1);
        n = (obs_q.size() < stim_q.size()) ? obs_q.size() : stim_q.size();
        for (int k = 0; k < n; k++) begin
            be = 0;
            if (!act) begin
                if (stim_q[k] != 0) begin act = 1; cnt = 1; zrun = 0; end
            end else begin
                cnt = (cnt < MAXC) ? cnt + 1 : MAXC;
                if (stim_q[k] == 0) begin
                    zrun++;
                    if (zrun == ZR + FL) begin act = 0; be = 1; end
                end else begin
                    zrun = 0;
                end
            end
            check($sformatf("%s[%0d] code", tag, k), obs_q[k].code, 32'(stim_q[k]));
            check($sformatf("%s[%0d] active", tag, k), obs_q[k].act, 32'(act));
            check($sformatf("%s[%0d] burst_end", tag, k), obs_q[k].be, 32'(be));
            check($sformatf("%s[%0d] sym_count", tag, k), obs_q[k].cnt, 32'(cnt));
            if (spacing && k > 0)
                check($sformatf("%s[%0d] spacing", tag, k), 32'(obs_q[k].cyc - obs_q[k-1].cyc), 32'(SYM));
        end
        obs_q.delete();
    endtask

    task automatic push_rand(input int len);
        for (int k = 0; k < len; k++) begin
            if (k == 0 || k == len - 1) stim_q.push_back(2'($urandom_range(3, 1)));
            else                        stim_q.push_back(2'($urandom_range(3)));
        end
    endtask

    task automatic push_zeros(input int len);
        for (int k = 0; k < len; k++) stim_q.push_back(2'd0);
    endtask

    int   bad;
    int   n;
    int   be0;
    logic [1:0] enc_seq [8];

    initial begin
        intf.code_in = 2'd0;
        enc_seq = '{2'd3, 2'd2, 2'd3, 2'd0, 2'd2, 2'd1, 2'd1, 2'd3};

        // Reset held while CodeIn toggles
        bad = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            intf.code_in = 2'($urandom);
            if (intf.code !== 0 || intf.sym_strobe !== 0 || intf.active !== 0 ||
                intf.burst_end !== 0 || intf.sym_count !== 0) bad++;
        end
        check("reset outputs", 32'(bad), 32'd0);
        check("reset sym_count", 32'(intf.sym_count), 32'd0);

        // Idle after release: strobes every SYM cycles, Active low
        intf.code_in = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;
        obs_q.delete();
        repeat (50) @(negedge clk);
        check("idle strobes", 32'(obs_q.size() >= 5), 32'd1);
        for (int k = 0; k < obs_q.size(); k++) begin
            check($sformatf("idle[%0d] active", k), obs_q[k].act, 32'd0);
            check($sformatf("idle[%0d] code", k), obs_q[k].code, 32'd0);
            if (k > 0) check($sformatf("idle[%0d] spacing", k), 32'(obs_q[k].cyc - obs_q[k-1].cyc), 32'(SYM));
        end

        // First-symbol latency: t0 is the first edge seeing the new CodeIn
        @(negedge clk);
        intf.code_in = 2'd3;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (intf.code !== 2'd3 && n < 40);
        check("latency edges", 32'(n), 32'(SYM / 2 + 4));
        check("latency active", 32'(intf.active), 32'd1);
        check("latency strobe", 32'(intf.sym_strobe), 32'd1);
        check("latency sym_count", 32'(intf.sym_count), 32'd1);
        be0 = be_total;
        @(negedge clk);
        intf.code_in = 2'd0;
        repeat ((ZR + FL) * SYM + 3 * SYM) @(negedge clk);
        check("single burst end pulse", 32'(be_total - be0), 32'd1);
        check("single burst active", 32'(intf.active), 32'd0);
        check("single burst count", 32'(intf.sym_count), 32'(1 + ZR + FL));
        obs_q.delete();

        // Directed encoder stream then full zero tail
        stim_q.delete();
        foreach (enc_seq[k]) stim_q.push_back(enc_seq[k]);
        push_zeros(ZR + FL);
        drive_stim(1'b0);
        check_stim("enc", 1'b1);

        // Re-lock inside FLUSH, zero run one short of the end, count saturation
        stim_q.delete();
        push_rand(20);
        push_zeros(ZR + 20);
        push_rand(10);
        push_zeros(ZR + FL - 1);
        push_rand(1);
        push_zeros(ZR + FL);
        drive_stim(1'b0);
        check_stim("relock", 1'b1);

        // Transition jitter of +-1 cycle
        stim_q.delete();
        push_rand(40);
        push_zeros(ZR + FL);
        drive_stim(1'b1);
        check_stim("jitter", 1'b0);

        // Reset pulse mid-burst
        @(negedge clk);
        intf.code_in = 2'd2;
        repeat (20) @(negedge clk);
        check("pre-reset active", 32'(intf.active), 32'd1);
        be0 = be_total;
        #3 rst_n = 1'b0;
        #1;
        check("mid reset active", 32'(intf.active), 32'd0);
        check("mid reset sym_count", 32'(intf.sym_count), 32'd0);
        check("mid reset code", 32'(intf.code), 32'd0);
        @(negedge clk);
        intf.code_in = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("mid reset no burst_end", 32'(be_total - be0), 32'd0);
        check("post reset active", 32'(intf.active), 32'd0);

        check("no active/burst_end off strobe", 32'(glitch), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
